// File: rtl/gray_pointer_source_pkg.sv
// Shared constants for the Gray-coded pointer source.
//
// Holds the default storage address width used by gray_pointer_source. The
// pointer width is derived locally inside the top module (address bits plus a
// wrap bit), so nothing width-dependent lives here.
package gray_pointer_source_pkg;

  // Default number of storage address bits; depth is 2**DefaultAddrWidth.
  localparam int unsigned DefaultAddrWidth = 4;

  // Minimum address width the full-flag comparison supports. It needs at
  // least one address bit so that the two pointer MSBs are distinct bits.
  localparam int unsigned MinAddrWidth = 1;

endpackage : gray_pointer_source_pkg

// File: rtl/gray_pointer_source_gray_code.sv
// Binary <-> Gray code converter (purely combinational).
//
// Parameters:
//   WIDTH   - number of bits converted.
//   INVERT  - 0: encode binary to Gray; 1: decode Gray to binary.
// Ports:
//   data_in   input  WIDTH  value to convert
//   data_out  output WIDTH  converted value
module gray_code #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          INVERT = 1'b0
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (!INVERT) begin : g_encode
    // Each Gray bit is the XOR of a binary bit and its upper neighbour.
    assign data_out = data_in ^ (data_in >> 1);
  end else begin : g_decode
    // Each binary bit is the XOR-reduction of all Gray bits at or above it.
    always_comb begin
      data_out = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        data_out[i] = ^(data_in >> i);
      end
    end
  end

endmodule : gray_code

// File: rtl/gray_pointer_source.sv
// Write-side pointer of a dual-clock FIFO.
//
// Keeps a binary write pointer with one wrap bit above the storage address,
// publishes it in Gray code from a flop for a destination-side synchronizer,
// and derives a registered full flag and a conservative occupancy from the
// consumer's Gray pointer (already synchronized into source_clock).
//
// Parameters:
//   ADDR_WIDTH  storage address bits; depth = 2**ADDR_WIDTH
// Ports:
//   source_clock         input   1          sole clock, rising edge
//   reset                input   1          synchronous reset, active-high
//   push_valid           input   1          producer requests one entry
//   push_ready           output  1          entry can be accepted this cycle
//   remote_gray_pointer  input   PTR_WIDTH  consumer Gray pointer (synchronized)
//   gray_pointer         output  PTR_WIDTH  registered Gray local pointer
//   write_address        output  ADDR_WIDTH storage address of next write
//   full                 output  1          registered full flag
//   level                output  PTR_WIDTH  registered conservative occupancy
module gray_pointer_source
  import gray_pointer_source_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                  source_clock,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [PTR_WIDTH-1:0]  remote_gray_pointer,
  output logic [PTR_WIDTH-1:0]  gray_pointer,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  full,
  output logic [PTR_WIDTH-1:0]  level
);

  // The two MSBs of a Gray pointer one full lap ahead differ from the
  // consumer's; all lower bits match. Built by shifting so it stays legal
  // down to a single address bit.
  localparam logic [PTR_WIDTH-1:0] FullMask = PTR_WIDTH'(2'b11) << (PTR_WIDTH - 2);

  logic [PTR_WIDTH-1:0] bin_q, bin_d;
  logic [PTR_WIDTH-1:0] gray_q, gray_d;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic                 full_q, full_d;
  logic [PTR_WIDTH-1:0] remote_bin;
  logic                 push_accept;

  // Elaboration-time guard against widths the full comparison cannot handle.
  if (ADDR_WIDTH < MinAddrWidth) begin : g_bad_width
    $error("gray_pointer_source: ADDR_WIDTH must be at least 1");
  end

  assign push_ready  = !full_q;
  assign push_accept = push_valid && push_ready;

  // Next binary pointer wraps naturally at 2**PTR_WIDTH.
  assign bin_d = bin_q + {{(PTR_WIDTH-1){1'b0}}, push_accept};

  gray_code #(
    .WIDTH  (PTR_WIDTH),
    .INVERT (1'b0)
  ) u_encode (
    .data_in  (bin_d),
    .data_out (gray_d)
  );

  gray_code #(
    .WIDTH  (PTR_WIDTH),
    .INVERT (1'b1)
  ) u_decode (
    .data_in  (remote_gray_pointer),
    .data_out (remote_bin)
  );

  // Both flags are computed from the next local pointer so they are exact for
  // the registered state; the remote view may lag, which only overstates level.
  always_comb begin
    full_d  = ((gray_d ^ remote_gray_pointer) == FullMask);
    level_d = bin_d - remote_bin;
  end

  always_ff @(posedge source_clock) begin
    if (reset) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  assign gray_pointer  = gray_q;
  assign write_address = bin_q[ADDR_WIDTH-1:0];
  assign full          = full_q;
  assign level         = level_q;

endmodule : gray_pointer_source

// File: tb/tb_gray_pointer_source.sv
// Directed bench for gray_pointer_source with ADDR_WIDTH=2 (PTR_WIDTH=3).
module tb_gray_pointer_source;

  localparam int unsigned AW = 2;
  localparam int unsigned PW = AW + 1;

  logic          clk;
  logic          reset;
  logic          push_valid;
  logic          push_ready;
  logic [PW-1:0] remote_gray_pointer;
  logic [PW-1:0] gray_pointer;
  logic [AW-1:0] write_address;
  logic          full;
  logic [PW-1:0] level;

  int total;
  int bad;

  // Observation vector: {gray, full, level, ready, addr}.
  logic [9:0] obs;
  logic [9:0] exp_v;
  assign obs = {gray_pointer, full, level, push_ready, write_address};

  // Gray sequence of a 3-bit counter, including the wrap back to zero.
  logic [2:0] gtab [0:8];

  gray_pointer_source #(
    .ADDR_WIDTH (AW)
  ) dut (
    .source_clock        (clk),
    .reset               (reset),
    .push_valid          (push_valid),
    .push_ready          (push_ready),
    .remote_gray_pointer (remote_gray_pointer),
    .gray_pointer        (gray_pointer),
    .write_address       (write_address),
    .full                (full),
    .level               (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push_valid = 1'b0;
    remote_gray_pointer = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_valid = 1'b1;
    remote_gray_pointer = '0;
    step();
    step();
    reset = 1'b0;
    push_valid = 1'b0;
    #1;
    total++;
    exp_v = {3'b000, 1'b0, 3'd0, 1'b1, 2'd0};
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL reset_state: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
    // Stays idle with no push.
    step();
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL reset_idle: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
  endtask

  task automatic test_fill();
    do_reset();
    push_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_v = {gtab[k+1], (k == 3), 3'(k + 1), (k != 3), 2'(k + 1)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL fill_push%0d: got {g,f,l,r,a}=%b want %b", k + 1, obs, exp_v);
      end
    end
    // Fifth push must be ignored.
    step();
    push_valid = 1'b0;
    exp_v = {3'b110, 1'b1, 3'd4, 1'b0, 2'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL fill_overflow: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
  endtask

  task automatic test_remote_release();
    // Continues from full state left by test_fill.
    push_valid = 1'b0;
    remote_gray_pointer = 3'b001;
    step();
    exp_v = {3'b110, 1'b0, 3'd3, 1'b1, 2'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL release_remote: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
    push_valid = 1'b1;
    step();
    push_valid = 1'b0;
    exp_v = {3'b111, 1'b1, 3'd4, 1'b0, 2'd1};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL release_refill: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] prev;
    do_reset();
    prev = 3'b000;
    for (int k = 0; k < 8; k++) begin
      remote_gray_pointer = gtab[k];
      push_valid = 1'b1;
      step();
      exp_v = {gtab[k+1], 1'b0, 3'd1, 1'b1, 2'(k + 1)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wrap_step%0d: got {g,f,l,r,a}=%b want %b", k + 1, obs, exp_v);
      end
      total++;
      if ($countones(gray_pointer ^ prev) != 1) begin
        bad++;
        $display("FAIL wrap_onebit%0d: got %b after %b want one-bit change",
                 k + 1, gray_pointer, prev);
      end
      prev = gray_pointer;
    end
    push_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_valid = 1'b1;
    step();
    step();
    exp_v = {3'b011, 1'b0, 3'd2, 1'b1, 2'd2};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL b2b_level2: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
    remote_gray_pointer = 3'b001;
    step();
    push_valid = 1'b0;
    exp_v = {3'b010, 1'b0, 3'd2, 1'b1, 2'd3};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL b2b_push_and_remote: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_valid = 1'b1;
    step();
    step();
    step();
    exp_v = {3'b010, 1'b0, 3'd3, 1'b1, 2'd3};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mid_level3: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
    reset = 1'b1;
    remote_gray_pointer = '0;
    step();
    reset = 1'b0;
    push_valid = 1'b0;
    exp_v = {3'b000, 1'b0, 3'd0, 1'b1, 2'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mid_reset: got {g,f,l,r,a}=%b want %b", obs, exp_v);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011;
    gtab[3] = 3'b010; gtab[4] = 3'b110; gtab[5] = 3'b111;
    gtab[6] = 3'b101; gtab[7] = 3'b100; gtab[8] = 3'b000;
    reset = 1'b1;
    push_valid = 1'b0;
    remote_gray_pointer = '0;

    test_reset();
    test_fill();
    test_remote_release();
    test_wrap();
    test_back_to_back();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_gray_pointer_source
